// File: rtl/aes_word_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_word_sequencer: drives the word-serial command protocol of the AES     |
// | core and exposes one-block-at-a-time valid/ready handshakes on both sides. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_word_sequencer #(
    parameter int CORE_LATENCY = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic [0:5]   aes_ctrl,
    output logic [0:31]  aes_din,
    input  logic [0:31]  aes_dout
);

    localparam logic [0:5] CMD_CLEAR   = 6'd0;
    localparam logic [0:5] CMD_LOAD    = 6'd1;
    localparam logic [0:5] CMD_ENCRYPT = 6'd2;
    localparam logic [0:5] CMD_DECRYPT = 6'd3;
    localparam logic [0:5] CMD_READ    = 6'd4;
    localparam logic [0:5] CMD_IDLE    = 6'd5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLEAR = 4'd1,
        ST_LOAD  = 4'd2,
        ST_LGAP  = 4'd3,
        ST_OP    = 4'd4,
        ST_OGAP  = 4'd5,
        ST_WAIT  = 4'd6,
        ST_READ  = 4'd7,
        ST_RGAP  = 4'd8,
        ST_DONE  = 4'd9
    } state_t;

    state_t       state;
    logic [1:0]   idx;
    logic [3:0]   wait_cnt;
    logic [0:127] blk;
    logic         mode;

    logic [1:0]   idx_next;
    logic [0:31]  next_word;

    assign idx_next  = idx + 2'd1;
    assign next_word = blk[{idx_next, 5'b00000} +: 32];

    // Outputs are registered: each transition loads the command of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            wait_cnt  <= 4'd0;
            blk       <= '0;
            mode      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            aes_ctrl  <= CMD_IDLE;
            aes_din   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        blk      <= in_data;
                        mode     <= in_mode;
                        idx      <= 2'd0;
                        in_ready <= 1'b0;
                        aes_ctrl <= CMD_CLEAR;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    aes_ctrl <= CMD_LOAD;
                    aes_din  <= blk[0:31];
                    state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    aes_ctrl <= CMD_IDLE;
                    state    <= ST_LGAP;
                end
                ST_LGAP: begin
                    if (idx == 2'd3) begin
                        idx      <= 2'd0;
                        aes_din  <= '0;
                        aes_ctrl <= mode ? CMD_DECRYPT : CMD_ENCRYPT;
                        state    <= ST_OP;
                    end else begin
                        idx      <= idx_next;
                        aes_din  <= next_word;
                        aes_ctrl <= CMD_LOAD;
                        state    <= ST_LOAD;
                    end
                end
                ST_OP: begin
                    aes_ctrl <= CMD_IDLE;
                    state    <= ST_OGAP;
                end
                ST_OGAP: begin
                    if (CORE_LATENCY == 0) begin
                        aes_ctrl <= CMD_READ;
                        state    <= ST_READ;
                    end else begin
                        wait_cnt <= 4'(CORE_LATENCY - 1);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        aes_ctrl <= CMD_READ;
                        state    <= ST_READ;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_READ: begin
                    out_data[{idx, 5'b00000} +: 32] <= aes_dout;
                    aes_ctrl <= CMD_IDLE;
                    state    <= ST_RGAP;
                end
                ST_RGAP: begin
                    if (idx == 2'd3) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx      <= idx_next;
                        aes_ctrl <= CMD_READ;
                        state    <= ST_READ;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    aes_ctrl <= CMD_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_word_sequencer.sv
`default_nettype none
// tb_aes_word_sequencer: two sequencers (latency 0 and 3) driving stand-in AES cores,
// checked every cycle against a command-list model of the block transaction.
module tb_aes_word_sequencer;

    localparam int NDUT = 2;
    localparam logic [0:127] PT   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [0:127] CT   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [0:127] KMIX = 128'h5a3c96e1_0f872d4b_c3a51e69_b4d27890;

    typedef struct {
        logic [0:5]  ctrl;
        logic [0:31] din;
    } step_t;

    logic         clk;
    logic         rst;
    logic         in_valid    [NDUT];
    logic         in_ready_s  [NDUT];
    logic [0:127] in_data     [NDUT];
    logic         in_mode     [NDUT];
    logic         out_valid_s [NDUT];
    logic         out_ready   [NDUT];
    logic [0:127] out_data_s  [NDUT];
    logic [0:5]   aes_ctrl_s  [NDUT];
    logic [0:31]  aes_din_s   [NDUT];
    logic [0:31]  aes_dout_s  [NDUT];

    int total = 0;
    int bad   = 0;

    int c_enc_seq [19] = '{0, 1, 5, 1, 5, 1, 5, 1, 5, 2, 5, 4, 5, 4, 5, 4, 5, 4, 5};
    logic [0:31] c_pt_words [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int d, input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL d%0d %s: got %h want %h at %0t", d, nm, act, exp, $time);
        end
    endtask

    // Stand-in for the AES core: the FIPS-197 known answer, otherwise an invertible byte-rotate/xor.
    function automatic logic [0:127] core_fn(input logic [0:127] b, input logic dec);
        logic [0:127] t;
        if (!dec && b == PT) return CT;
        if (dec && b == CT) return PT;
        if (!dec) return {b[8:127], b[0:7]} ^ KMIX;
        t = b ^ KMIX;
        return {t[120:127], t[0:119]};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 0 : 3;

        aes_word_sequencer #(.CORE_LATENCY(LAT)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready_s[g]),
            .in_data   (in_data[g]),
            .in_mode   (in_mode[g]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data_s[g]),
            .aes_ctrl  (aes_ctrl_s[g]),
            .aes_din   (aes_din_s[g]),
            .aes_dout  (aes_dout_s[g])
        );

        logic [0:31]  core_words [4];
        logic [1:0]   core_ld;
        logic [1:0]   core_rd;
        logic [0:127] core_res;

        always @(posedge clk) begin
            case (aes_ctrl_s[g])
                6'd0: begin core_ld <= 2'd0; core_rd <= 2'd0; end
                6'd1: begin core_words[core_ld] <= aes_din_s[g]; core_ld <= core_ld + 2'd1; end
                6'd2, 6'd3: begin
                    core_res <= core_fn({core_words[0], core_words[1], core_words[2], core_words[3]},
                                        aes_ctrl_s[g] == 6'd3);
                    core_rd  <= 2'd0;
                end
                6'd4: core_rd <= core_rd + 2'd1;
                default: ;
            endcase
        end

        assign aes_dout_s[g] = (aes_ctrl_s[g] == 6'd4) ? core_res[{core_rd, 5'b00000} +: 32] : 32'hdeadbeef;

        // Model: 0 = waiting for a block, 1 = replaying the expected command list, 2 = result held.
        step_t        exp_q [$];
        logic [0:127] exp_out;
        int           phase = 0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                exp_q.delete();
                phase = 0;
            end else if (phase == 0) begin
                if (in_valid[g]) begin
                    exp_q.push_back(step_t'{6'd0, 32'd0});
                    for (int w = 0; w < 4; w++) begin
                        exp_q.push_back(step_t'{6'd1, in_data[g][32*w +: 32]});
                        exp_q.push_back(step_t'{6'd5, in_data[g][32*w +: 32]});
                    end
                    exp_q.push_back(step_t'{in_mode[g] ? 6'd3 : 6'd2, 32'd0});
                    exp_q.push_back(step_t'{6'd5, 32'd0});
                    for (int w = 0; w < LAT; w++) exp_q.push_back(step_t'{6'd5, 32'd0});
                    for (int w = 0; w < 4; w++) begin
                        exp_q.push_back(step_t'{6'd4, 32'd0});
                        exp_q.push_back(step_t'{6'd5, 32'd0});
                    end
                    exp_out = core_fn(in_data[g], in_mode[g]);
                    phase = 1;
                end
            end else if (phase == 1) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) phase = 2;
            end else begin
                if (out_ready[g]) phase = 0;
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                if (phase == 0) begin
                    chk(g, "idle_ready", in_ready_s[g], 1);
                    chk(g, "idle_valid", out_valid_s[g], 0);
                    chk(g, "idle_ctrl", aes_ctrl_s[g], 5);
                    chk(g, "idle_din", aes_din_s[g], 0);
                end else if (phase == 1) begin
                    chk(g, "busy_ctrl", aes_ctrl_s[g], exp_q[0].ctrl);
                    chk(g, "busy_din", aes_din_s[g], exp_q[0].din);
                    chk(g, "busy_ready", in_ready_s[g], 0);
                    chk(g, "busy_valid", out_valid_s[g], 0);
                end else begin
                    chk(g, "done_valid", out_valid_s[g], 1);
                    chk(g, "done_data", out_data_s[g], exp_out);
                    chk(g, "done_ready", in_ready_s[g], 0);
                    chk(g, "done_ctrl", aes_ctrl_s[g], 5);
                end
            end
        end
    end

    // Presents a block and returns once it has been accepted; n = edges waited including the accepting one.
    task automatic send(input int d, input logic [0:127] data, input logic m, output int n);
        bit acc;
        acc = 1'b0;
        n = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_mode[d]  = m;
        while (!acc && n < 200) begin
            acc = in_ready_s[d];
            @(posedge clk); #2;
            n++;
        end
        in_valid[d] = 1'b0;
        if (!acc) chk(d, "send_timeout", 0, 1);
    endtask

    // Called in cycle 1 after acceptance; n = cycle index in which out_valid is seen.
    task automatic wait_valid(input int d, input int budget, output int n);
        n = 1;
        while (!out_valid_s[d] && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (!out_valid_s[d]) chk(d, "valid_timeout", 0, 1);
    endtask

    task automatic rand_run(input int d, input int blocks);
        int n;
        logic [0:127] b;
        logic m;
        for (int k = 0; k < blocks; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            b = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            out_ready[d] = 1'($urandom_range(0, 1));
            send(d, b, m, n);
            wait_valid(d, 60, n);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
            out_ready[d] = 1'b1;
            @(posedge clk); #2;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        logic [0:127] snap;
        logic [0:127] b;

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_mode[d]   = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < NDUT; d++) begin
            chk(d, "rst_ready", in_ready_s[d], 1);
            chk(d, "rst_valid", out_valid_s[d], 0);
            chk(d, "rst_data", out_data_s[d], 0);
            chk(d, "rst_ctrl", aes_ctrl_s[d], 5);
            chk(d, "rst_din", aes_din_s[d], 0);
        end
        rst = 1'b0;
        @(posedge clk); #2;

        // FIPS-197 encrypt: exact command list, loaded words, result in cycle 20
        send(0, PT, 1'b0, n);
        for (int k = 0; k < 19; k++) begin
            chk(0, "enc_seq", aes_ctrl_s[0], c_enc_seq[k]);
            if (k == 1 || k == 3 || k == 5 || k == 7) chk(0, "enc_din", aes_din_s[0], c_pt_words[k/2]);
            @(posedge clk); #2;
        end
        chk(0, "enc_valid_c20", out_valid_s[0], 1);
        chk(0, "enc_result", out_data_s[0], CT);
        @(posedge clk); #2;

        // FIPS-197 decrypt
        send(0, CT, 1'b1, n);
        for (int k = 0; k < 19; k++) begin
            if (k == 9) chk(0, "dec_op", aes_ctrl_s[0], 3);
            @(posedge clk); #2;
        end
        chk(0, "dec_valid_c20", out_valid_s[0], 1);
        chk(0, "dec_result", out_data_s[0], PT);
        @(posedge clk); #2;

        // Backpressure with a second block waiting
        out_ready[0] = 1'b0;
        b = {$urandom, $urandom, $urandom, $urandom};
        send(0, b, 1'b0, n);
        wait_valid(0, 40, n);
        snap = out_data_s[0];
        chk(0, "bp_first", snap, core_fn(b, 1'b0));
        b = {$urandom, $urandom, $urandom, $urandom};
        in_valid[0] = 1'b1;
        in_data[0]  = b;
        in_mode[0]  = 1'b1;
        repeat (10) begin
            chk(0, "bp_ready", in_ready_s[0], 0);
            chk(0, "bp_hold", out_data_s[0], snap);
            @(posedge clk); #2;
        end
        out_ready[0] = 1'b1;
        send(0, b, 1'b1, n);
        chk(0, "bp_accept_edges", n, 2);
        wait_valid(0, 40, n);
        chk(0, "bp_second", out_data_s[0], core_fn(b, 1'b1));
        @(posedge clk); #2;

        // CORE_LATENCY=3 instance: three idle cycles before first READ, valid in cycle 23
        b = {$urandom, $urandom, $urandom, $urandom};
        send(1, b, 1'b0, n);
        for (int c = 1; c < 23; c++) begin
            if (c >= 11 && c <= 14) chk(1, "lat_gap", aes_ctrl_s[1], 5);
            if (c == 15) chk(1, "lat_read", aes_ctrl_s[1], 4);
            if (c == 22) chk(1, "lat_valid_c22", out_valid_s[1], 0);
            @(posedge clk); #2;
        end
        chk(1, "lat_valid_c23", out_valid_s[1], 1);
        chk(1, "lat_result", out_data_s[1], core_fn(b, 1'b0));
        @(posedge clk); #2;

        // Inputs altered right after acceptance
        b = {$urandom, $urandom, $urandom, $urandom};
        send(0, b, 1'b0, n);
        in_data[0] = ~b;
        in_mode[0] = 1'b1;
        wait_valid(0, 40, n);
        chk(0, "chg_result", out_data_s[0], core_fn(b, 1'b0));
        @(posedge clk); #2;

        // Asynchronous reset during LOAD
        b = {$urandom, $urandom, $urandom, $urandom};
        send(0, b, 1'b0, n);
        @(posedge clk); #2;
        chk(0, "pre_rst_load", aes_ctrl_s[0], 1);
        #1 rst = 1'b1;
        #1;
        chk(0, "arst_ctrl", aes_ctrl_s[0], 5);
        chk(0, "arst_ready", in_ready_s[0], 1);
        chk(0, "arst_valid", out_valid_s[0], 0);
        chk(0, "arst_din", aes_din_s[0], 0);
        chk(0, "arst_data", out_data_s[0], 0);
        @(posedge clk); #2;
        rst = 1'b0;
        b = {$urandom, $urandom, $urandom, $urandom};
        send(0, b, 1'b1, n);
        wait_valid(0, 40, n);
        chk(0, "post_rst_result", out_data_s[0], core_fn(b, 1'b1));
        @(posedge clk); #2;

        // Randomized traffic on both instances
        fork
            rand_run(0, 30);
            rand_run(1, 30);
        join
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_word_sequencer.md
# aes_word_sequencer

Upstream driver for the ENGG4560_aes core. Accepts one 128-bit block plus an encrypt/decrypt mode over a valid/ready handshake. Issues the core's 6-bit command stream: clear, four word loads, operation, four word reads. Reassembles the four 32-bit result words into a 128-bit output held under a valid/ready handshake. It isolates the rest of the design from the core's word-serial command protocol.

## Interface
Parameters:
- CORE_LATENCY, default 0: extra idle cycles inserted after the ENCRYPT/DECRYPT command before the first READ (range 0-15).

Ports (bit 0 is the MSB on every bus):
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream block available.
- in_ready  out  1  sequencer can accept a block.
- in_data  in  128  block; word 0 = in_data[0:31] is sent first.
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with in_data.
- out_valid  out  1  result block available.
- out_ready  in  1  downstream accepts result.
- out_data  out  128  result; first word read lands in out_data[0:31].
- aes_ctrl  out  6  command to core: 0 CLEAR, 1 LOAD_WORD, 2 ENCRYPT, 3 DECRYPT, 4 READ_WORD, 5 IDLE.
- aes_din  out  32  word presented to the core during LOAD_WORD.
- aes_dout  in  32  word returned by the core during READ_WORD.

## Operation
- FSM states: IDLE, CLEAR, LOAD, LGAP, OP, OGAP, WAIT, READ, RGAP, DONE.
- IDLE: in_ready=1, aes_ctrl=5. On in_valid&&in_ready, capture in_data/in_mode, clear word index, go to CLEAR.
- CLEAR: aes_ctrl=0 for 1 cycle, then LOAD.
- LOAD: aes_ctrl=1, aes_din = captured word[idx], 1 cycle, then LGAP. LGAP: aes_ctrl=5, aes_din held, 1 cycle. Then idx++ and back to LOAD, or go to OP after idx 3.
- OP: aes_ctrl = 2 (mode 0) or 3 (mode 1), 1 cycle. OGAP: aes_ctrl=5, 1 cycle. Then WAIT for CORE_LATENCY cycles, or skip WAIT if the parameter is 0. idx reset to 0.
- READ: aes_ctrl=4, 1 cycle. aes_dout is registered into out_data word[idx] at the edge ending READ. RGAP: aes_ctrl=5, 1 cycle. Then idx++ and back to READ, or go to DONE after idx 3.
- DONE: out_valid=1, out_data stable. On out_ready, go to IDLE. in_ready=0 in DONE; no overlap between blocks.
- aes_din = 0 outside LOAD/LGAP.
- Only one command is issued per cycle. Every non-IDLE command is followed by exactly one IDLE-code cycle.
- in_data and in_mode changes after acceptance have no effect on the current block.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, aes_ctrl=5, aes_din=0, state IDLE, idx=0.
- Acceptance at edge E0:
  - cycles 1..19+CORE_LATENCY carry CLEAR, 4×(LOAD,IDLE), OP, IDLE, WAIT×L, 4×(READ,IDLE);
  - out_valid rises in cycle 20+CORE_LATENCY (20 with defaults).
- Back-to-back throughput: one block per 21+CORE_LATENCY cycles, with out_ready tied high.
- out_valid stays asserted with out_data unchanged until the out_ready edge. out_valid falls the next cycle, and in_ready rises in the same cycle.
- in_valid held high while in_ready=0 is ignored. The block is not consumed until in_ready=1.
- Reset mid-operation: all outputs return to reset values immediately (async). The partial block is discarded. The next block starts with CLEAR, so leftover core state is irrelevant.
- out_data words not yet read in the current block keep their values from the previous block until overwritten.

## Test plan
- Reset: assert rst mid-LOAD -> aes_ctrl=5, in_ready=1, out_valid=0 in the same cycle. Next block completes correctly.
- Encrypt: in_data=00112233_44556677_8899aabb_ccddeeff, mode 0, core model with FIPS-197 key 000102..0f.
  - aes_ctrl sequence 0,1,5,1,5,1,5,1,5,2,5,4,5,4,5,4,5,4,5.
  - aes_din words issued in order.
  - out_data=69c4e0d8_6a7b0430_d8cdb780_70b4c55a, out_valid at cycle 20.
- Decrypt: in_data=69c4e0d8_6a7b0430_d8cdb780_70b4c55a, mode 1 -> OP cycle shows aes_ctrl=3; out_data=00112233_44556677_8899aabb_ccddeeff.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and a new block -> out_data stable, in_ready=0. Release -> second block accepted one cycle later.
- CORE_LATENCY=3: exactly 3 extra IDLE cycles between OP's gap and the first READ; out_valid at cycle 23.
- Input change: alter in_data/in_mode one cycle after acceptance -> result matches the originally captured block.
